// File: rtl/mem_reduce_engine.sv
// mem_reduce_engine: reads LENGTH words from memory, reduces them (wrap sum, saturating sum or max)
// and writes the result back to a destination address before pulsing done.
module mem_reduce_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [1:0]        mode,
    output logic              ready,
    output logic              done,
    output logic              overflow,
    output logic [ACC_W-1:0]  result,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read_enable,
    output logic              mem_write_enable,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);
    typedef enum logic [2:0] {IDLE, READ, ACC, WRITE, DONE} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d, dest_q, dest_d;
    logic [ADDR_W:0]    rem_q, rem_d;
    logic [1:0]         mode_q, mode_d;
    logic [ACC_W-1:0]   acc_q, acc_d, result_q, result_d, d_ext;
    logic               ovf_q, ovf_d;
    logic [ACC_W:0]     sum;

    assign d_ext = ACC_W'(mem_data_out);
    assign sum   = {1'b0, acc_q} + {1'b0, d_ext};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            dest_q   <= '0;
            rem_q    <= '0;
            mode_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            dest_q   <= dest_d;
            rem_q    <= rem_d;
            mode_q   <= mode_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? ((length != '0) ? READ : WRITE) : IDLE;
            READ:    state_d = ACC;
            ACC:     state_d = (rem_q != (ADDR_W+1)'(1)) ? READ : WRITE;
            WRITE:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d    = ptr_q;
        dest_d   = dest_q;
        rem_d    = rem_q;
        mode_d   = mode_q;
        acc_d    = acc_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        if (state_q == IDLE && start) begin
            ptr_d    = base_addr;
            dest_d   = dest_addr;
            rem_d    = length;
            mode_d   = mode;
            acc_d    = '0;
            result_d = '0;
            ovf_d    = 1'b0;
        end else if (state_q == ACC) begin
            ptr_d = ptr_q + ADDR_W'(1);
            rem_d = rem_q - (ADDR_W+1)'(1);
            // modes 00 and 11 both wrap; only max leaves overflow alone
            acc_d = (mode_q == 2'b10) ? ((d_ext > acc_q) ? d_ext : acc_q) :
                    (mode_q == 2'b01 && sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
            ovf_d = ovf_q | ((mode_q != 2'b10) && sum[ACC_W]);
        end else if (state_q == WRITE) begin
            result_d = acc_q;
        end
    end

    always_comb begin
        ready            = (state_q == IDLE);
        done             = (state_q == DONE);
        mem_read_enable  = (state_q == READ);
        mem_write_enable = (state_q == WRITE);
        mem_address      = (state_q == READ) ? ptr_q : (state_q == WRITE) ? dest_q : '0;
        mem_data_in      = (state_q != WRITE) ? '0 :
                           (mode_q == 2'b01 && (acc_q >> DATA_W) != '0) ? '1 : acc_q[DATA_W-1:0];
        overflow         = ovf_q;
        result           = result_q;
    end
endmodule

// File: tb/tb_mem_reduce_engine.sv
// tb_mem_reduce_engine: directed vector table plus hand sequences for reset, handshake and abort.
module tb_mem_reduce_engine;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  base_addr = '0, dest_addr = '0;
    logic [5:0]  length = '0;
    logic [1:0]  mode = '0;
    logic        ready, done, overflow, mem_read_enable, mem_write_enable;
    logic [15:0] result, mem_data_in, mem_data_out;
    logic [4:0]  mem_address;

    logic [15:0] mem [32];
    logic [15:0] rdata;
    logic        pl_en = 1'b0;
    logic [4:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;
    logic [4:0]  rd_log [512];
    int          rd_total = 0, wr_total = 0, done_total = 0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    mem_reduce_engine dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
        .dest_addr(dest_addr), .mode(mode), .ready(ready), .done(done), .overflow(overflow),
        .result(result), .mem_address(mem_address), .mem_read_enable(mem_read_enable),
        .mem_write_enable(mem_write_enable), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    assign mem_data_out = rdata;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mem_write_enable) begin
            mem[mem_address] <= mem_data_in;
            wr_total <= wr_total + 1;
        end
        if (mem_read_enable) begin
            rdata <= mem[mem_address];
            rd_log[rd_total] <= mem_address;
            rd_total <= rd_total + 1;
        end
        if (done) done_total <= done_total + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input int a, input logic [15:0] v);
        @(negedge clk);
        pl_en = 1'b1;
        pl_addr = 5'(a);
        pl_data = v;
    endtask

    task automatic poke_end();
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic strobe_chk(input string tag);
        chk({tag, "_strobes"}, {31'd0, (mem_read_enable && mem_write_enable) ||
            (!mem_read_enable && !mem_write_enable && (mem_address != 0 || mem_data_in != 0))}, 0);
    endtask

    task automatic run(input logic [4:0] b, input logic [5:0] n, input logic [4:0] d, input logic [1:0] m,
                       input logic [15:0] er, input logic eo, input logic [15:0] em, input string tag);
        int r0, w0, k;
        r0 = rd_total;
        w0 = wr_total;
        @(negedge clk);
        base_addr = b; length = n; dest_addr = d; mode = m; start = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            k++;
            strobe_chk(tag);
        end while (!done && k < 200);
        chk({tag, "_latency"}, 32'(k), 32'(2 * n + 2));
        chk({tag, "_result"}, {16'd0, result}, {16'd0, er});
        chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, eo});
        chk({tag, "_mem_dest"}, {16'd0, mem[d]}, {16'd0, em});
        chk({tag, "_reads"}, 32'(rd_total - r0), 32'(n));
        chk({tag, "_writes"}, 32'(wr_total - w0), 1);
        for (int i = 0; i < int'(n); i++)
            chk($sformatf("%s_rdaddr%0d", tag, i), {27'd0, rd_log[r0 + i]}, 32'((int'(b) + i) % 32));
        @(negedge clk);
        chk({tag, "_ready_after"}, {31'd0, ready}, 1);
        chk({tag, "_done_pulse"}, {31'd0, done}, 0);
    endtask

    typedef struct {
        logic [4:0]  b;
        logic [5:0]  n;
        logic [4:0]  d;
        logic [1:0]  m;
        logic [15:0] w [4];
        logic [15:0] er;
        logic        eo;
        logic [15:0] em;
    } vec_t;

    vec_t tv [8];

    initial begin
        int r0, w0, d0;
        tv[0] = '{5'd4,  6'd4, 5'd20, 2'd0, '{16'd1, 16'd2, 16'd3, 16'd4},       16'd10,     1'b0, 16'd10};
        tv[1] = '{5'd0,  6'd3, 5'd10, 2'd1, '{16'hF000, 16'h2000, 16'h0001, 16'd0}, 16'hFFFF, 1'b1, 16'hFFFF};
        tv[2] = '{5'd0,  6'd3, 5'd11, 2'd0, '{16'hF000, 16'h2000, 16'h0001, 16'd0}, 16'h1001, 1'b1, 16'h1001};
        tv[3] = '{5'd30, 6'd4, 5'd12, 2'd2, '{16'd7, 16'h8000, 16'd3, 16'd9},    16'h8000,   1'b0, 16'h8000};
        tv[4] = '{5'd5,  6'd0, 5'd15, 2'd0, '{16'd0, 16'd0, 16'd0, 16'd0},       16'd0,      1'b0, 16'd0};
        tv[5] = '{5'd0,  6'd3, 5'd2,  2'd3, '{16'd5, 16'd6, 16'd7, 16'd0},       16'd18,     1'b0, 16'd18};
        tv[6] = '{5'd8,  6'd2, 5'd16, 2'd1, '{16'd100, 16'd200, 16'd0, 16'd0},   16'd300,    1'b0, 16'd300};
        tv[7] = '{5'd31, 6'd1, 5'd0,  2'd2, '{16'hFFFF, 16'd0, 16'd0, 16'd0},    16'hFFFF,   1'b0, 16'hFFFF};

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_ready", {31'd0, ready}, 1);
            chk("rst_outs", {done, overflow, mem_read_enable, mem_write_enable, 11'd0, mem_address, 16'd0}, 0);
            chk("rst_data", {result, mem_data_in}, 0);
        end
        reset = 1'b1;
        r0 = rd_total;
        w0 = wr_total;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            strobe_chk("idle");
            chk("idle_ready", {31'd0, ready}, 1);
        end
        chk("idle_no_access", 32'(rd_total - r0 + wr_total - w0), 0);

        for (int t = 0; t < 8; t++) begin
            poke(tv[t].d, 16'hDEAD);
            for (int j = 0; j < int'(tv[t].n); j++) poke((int'(tv[t].b) + j) % 32, tv[t].w[j]);
            poke_end();
            run(tv[t].b, tv[t].n, tv[t].d, tv[t].m, tv[t].er, tv[t].eo, tv[t].em, $sformatf("vec%0d", t));
        end

        for (int i = 0; i < 32; i++) poke(i, 16'(i + 1));
        poke_end();
        run(5'd7, 6'd32, 5'd3, 2'd0, 16'd528, 1'b0, 16'd528, "len32");

        poke(0, 16'd11);
        poke(1, 16'd22);
        poke(9, 16'hDEAD);
        poke_end();
        d0 = done_total;
        @(negedge clk);
        base_addr = 5'd0; length = 6'd2; dest_addr = 5'd9; mode = 2'd0; start = 1'b1;
        @(negedge clk);
        base_addr = 5'd10; length = 6'd1; dest_addr = 5'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk("hs_single_done", 32'(done_total - d0), 1);
        chk("hs_mem_dest", {16'd0, mem[9]}, 33);
        chk("hs_result", {16'd0, result}, 33);

        poke(25, 16'hDEAD);
        for (int i = 12; i < 16; i++) poke(i, 16'd1);
        poke_end();
        w0 = wr_total;
        d0 = done_total;
        @(negedge clk);
        base_addr = 5'd12; length = 6'd4; dest_addr = 5'd25; mode = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_in_acc", {31'd0, mem_read_enable | ready | done}, 0);
        reset = 1'b0;
        #1;
        chk("abort_ready", {31'd0, ready}, 1);
        chk("abort_strobes", {30'd0, mem_read_enable, mem_write_enable}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_write", 32'(wr_total - w0), 0);
        chk("abort_no_done", 32'(done_total - d0), 0);
        chk("abort_mem_dest", {16'd0, mem[25]}, 32'hDEAD);
        run(5'd12, 6'd4, 5'd25, 2'd0, 16'd4, 1'b0, 16'd4, "after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
